// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit RISC CPU: function-select and B-mux codes,
// datapath widths and the packed status-flag record.
package risc16_pkg;

    localparam int WIDTH = 16;
    localparam int NREG  = 16;
    localparam int REGW  = $clog2(NREG);
    localparam int PCW   = 6;

    typedef enum logic [3:0] {
        FS_TRA   = 4'b0000,
        FS_INC   = 4'b0001,
        FS_ADD   = 4'b0010,
        FS_ADDC  = 4'b0011,
        FS_ADDNB = 4'b0100,
        FS_SUB   = 4'b0101,
        FS_DEC   = 4'b0110,
        FS_AND   = 4'b1000,
        FS_OR    = 4'b1001,
        FS_XOR   = 4'b1010,
        FS_NOT   = 4'b1011,
        FS_TRB   = 4'b1100,
        FS_SHR   = 4'b1101,
        FS_SHL   = 4'b1110
    } fs_e;

    typedef enum logic [1:0] {
        MB_REG  = 2'b00,
        MB_IMM  = 2'b01,
        MB_PC   = 2'b10,
        MB_ZERO = 2'b11
    } mb_e;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

endpackage

// File: rtl/risc16_datapath_if.sv
// Controller <-> datapath bundle: control word and operands in, buses, memory
// port and flags out. The master side is the Controller.
interface risc16_datapath_if;
    import risc16_pkg::*;

    logic             MD;
    logic             RW;
    logic             MW;
    logic [1:0]       MB;
    logic [3:0]       FS;
    logic [REGW-1:0]  DR;
    logic [REGW-1:0]  SA;
    logic [REGW-1:0]  SB;
    logic [PCW-1:0]   PC;
    logic [WIDTH-1:0] imdt;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] bus_A;
    logic [WIDTH-1:0] bus_B;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic             V;
    logic             C;
    logic             N;
    logic             Z;

    modport master (
        output MD, RW, MW, MB, FS, DR, SA, SB, PC, imdt, mem_rdata,
        input  bus_A, bus_B, mem_addr, mem_wdata, mem_we, V, C, N, Z
    );

    modport slave (
        input  MD, RW, MW, MB, FS, DR, SA, SB, PC, imdt, mem_rdata,
        output bus_A, bus_B, mem_addr, mem_wdata, mem_we, V, C, N, Z
    );

endinterface

// File: rtl/risc16_regfile.sv
// 16x16 register file: one synchronous write port, two combinational read
// ports, no write-through bypass, whole array cleared by async reset.
module risc16_regfile
    import risc16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [REGW-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [REGW-1:0]  raddrA_i,
    input  logic [REGW-1:0]  raddrB_i,
    output logic [WIDTH-1:0] rdataA_o,
    output logic [WIDTH-1:0] rdataB_o
);

    logic [WIDTH-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o = regs_q[raddrA_i];
    assign rdataB_o = regs_q[raddrB_i];

endmodule

// File: rtl/risc16_datapath.sv
// Execution datapath: register file, B-operand mux, function unit and the
// V/C/N/Z flag register feeding branch decisions back to the Controller.
module risc16_datapath
    import risc16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    risc16_datapath_if.slave bus
);

    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] busB;
    logic [WIDTH-1:0] bAdj;
    logic [WIDTH-1:0] fOut;
    logic [WIDTH-1:0] wData;
    logic [WIDTH:0]   sum;
    logic             cin;
    logic             useAdder;
    flags_t           flags_q;
    flags_t           flags_d;

    risc16_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.RW),
        .waddr_i  (bus.DR),
        .wdata_i  (wData),
        .raddrA_i (bus.SA),
        .raddrB_i (bus.SB),
        .rdataA_o (busA),
        .rdataB_o (regB)
    );

    always_comb begin
        busB = '0;
        case (bus.MB)
            MB_REG:  busB = regB;
            MB_IMM:  busB = bus.imdt;
            MB_PC:   busB = {{(WIDTH-PCW){1'b0}}, bus.PC};
            default: busB = '0;
        endcase
    end

    // Every arithmetic code is one 17-bit add of A, an adjusted B and a carry-in;
    // bit 16 of that sum is the carry flag.
    always_comb begin
        bAdj     = '0;
        cin      = 1'b0;
        useAdder = 1'b0;
        fOut     = busA;
        case (bus.FS)
            FS_INC:   begin useAdder = 1'b1; cin = 1'b1; end
            FS_ADD:   begin useAdder = 1'b1; bAdj = busB; end
            FS_ADDC:  begin useAdder = 1'b1; bAdj = busB; cin = 1'b1; end
            FS_ADDNB: begin useAdder = 1'b1; bAdj = ~busB; end
            FS_SUB:   begin useAdder = 1'b1; bAdj = ~busB; cin = 1'b1; end
            FS_DEC:   begin useAdder = 1'b1; bAdj = '1; end
            FS_AND:   fOut = busA & busB;
            FS_OR:    fOut = busA | busB;
            FS_XOR:   fOut = busA ^ busB;
            FS_NOT:   fOut = ~busA;
            FS_TRB:   fOut = busB;
            FS_SHR:   fOut = {1'b0, busB[WIDTH-1:1]};
            FS_SHL:   fOut = {busB[WIDTH-2:0], 1'b0};
            4'b1111:  fOut = busB;
            default:  fOut = busA;
        endcase
        sum = {1'b0, busA} + {1'b0, bAdj} + {{WIDTH{1'b0}}, cin};
        if (useAdder) begin
            fOut = sum[WIDTH-1:0];
        end
    end

    assign wData = bus.MD ? bus.mem_rdata : fOut;

    // Flags only track function-unit results written back; loads and idle cycles hold them.
    always_comb begin
        flags_d = flags_q;
        if (bus.RW && !bus.MD) begin
            flags_d.z = (fOut == '0);
            flags_d.n = fOut[WIDTH-1];
            flags_d.c = useAdder & sum[WIDTH];
            flags_d.v = useAdder & (busA[WIDTH-1] == bAdj[WIDTH-1])
                                 & (fOut[WIDTH-1] != busA[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.bus_A     = busA;
    assign bus.bus_B     = busB;
    assign bus.mem_addr  = busA;
    assign bus.mem_wdata = busB;
    assign bus.mem_we    = bus.MW & ~rst;
    assign bus.V         = flags_q.v;
    assign bus.C         = flags_q.c;
    assign bus.N         = flags_q.n;
    assign bus.Z         = flags_q.z;

endmodule
